coreid_reader: RTL and testbench



---
 rtl/zxuno_regs_pkg.sv | 27 ++
 rtl/coreid_reader_if.sv | 21 ++
 rtl/coreid_reader_buf.sv | 23 ++
 rtl/coreid_reader.sv | 152 +++++++++++++++
 tb/tb_coreid_reader.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/zxuno_regs_pkg.sv
// Shared ZX-UNO register-bus definitions: register addresses, reader FSM encoding, default timing.
package zxuno_regs_pkg;

  localparam logic [7:0]  REG_COREID     = 8'hFF;

  localparam int unsigned DEF_MAX_LEN    = 16;
  localparam int unsigned DEF_RD_CYCLES  = 2;
  localparam int unsigned DEF_GAP_CYCLES = 2;

  localparam int unsigned LEN_W          = 5;
  localparam int unsigned CYC_W          = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_SELECT = 3'd2,
    ST_RDON   = 3'd3,
    ST_RDOFF  = 3'd4,
    ST_FIN    = 3'd5
  } coreid_state_e;

  // States in which the reader keeps the register address selected.
  function automatic logic addr_driven(input coreid_state_e s);
    return (s == ST_SELECT) || (s == ST_RDON) || (s == ST_RDOFF) || (s == ST_FIN);
  endfunction

endpackage

// File: rtl/coreid_reader_if.sv
// ZX-UNO register bus as seen by an initiator (master) and the register file (slave).
interface coreid_reader_if;

  logic       bus_req;
  logic       bus_gnt;
  logic [7:0] zxuno_addr;
  logic       regaddr_changed;
  logic       zxuno_regrd;
  logic [7:0] din;

  modport master (
    output bus_req, zxuno_addr, regaddr_changed, zxuno_regrd,
    input  bus_gnt, din
  );

  modport slave (
    input  bus_req, zxuno_addr, regaddr_changed, zxuno_regrd,
    output bus_gnt, din
  );

endinterface

// File: rtl/coreid_reader_buf.sv
// Core ID capture buffer: single write port, asynchronous read, contents not reset.
module coreid_buf #(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Store a captured byte.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/coreid_reader.sv
// Fetches the core ID string from the ZX-UNO ID register into a local buffer.
// Optional running byte checksum on csum: define COREID_READER_CSUM_EN.
module coreid_reader
  import zxuno_regs_pkg::*;
#(
  parameter int unsigned MAX_LEN    = DEF_MAX_LEN,
  parameter logic [7:0]  REG_ADDR   = REG_COREID,
  parameter int unsigned RD_CYCLES  = DEF_RD_CYCLES,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  coreid_reader_if.master        bus,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [LEN_W-1:0]       len,
  input  logic [3:0]             rd_idx,
  output logic [7:0]             rd_data,
  output logic [7:0]             csum
);

  localparam int unsigned AW = $clog2(MAX_LEN);

  coreid_state_e      state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic               err_q, err_d;
  logic               nul_q, nul_d;
  logic               buf_we;

  // Next state, counters and capture strobe.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cyc_d   = cyc_q;
    err_d   = err_q;
    nul_d   = nul_q;
    buf_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_REQ;
          len_d   = '0;
          cyc_d   = '0;
          err_d   = 1'b0;
          nul_d   = 1'b0;
        end
      end
      ST_REQ: begin
        if (bus.bus_gnt) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (!bus.bus_gnt) begin
          state_d = ST_FIN;
          err_d   = 1'b1;
        end else begin
          state_d = ST_RDON;
          cyc_d   = '0;
        end
      end
      ST_RDON: begin
        if (!bus.bus_gnt) begin
          state_d = ST_FIN;
          err_d   = 1'b1;
        end else if (cyc_q == CYC_W'(RD_CYCLES - 1)) begin
          state_d = ST_RDOFF;
          cyc_d   = '0;
          if (bus.din == 8'h00) begin
            nul_d = 1'b1;
          end else if (len_q != LEN_W'(MAX_LEN)) begin
            buf_we = 1'b1;
            len_d  = len_q + LEN_W'(1);
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_RDOFF: begin
        if (!bus.bus_gnt) begin
          state_d = ST_FIN;
          err_d   = 1'b1;
        end else if (cyc_q == CYC_W'(GAP_CYCLES - 1)) begin
          cyc_d   = '0;
          state_d = (nul_q || (len_q == LEN_W'(MAX_LEN))) ? ST_FIN : ST_RDON;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; bus-facing outputs are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= ST_IDLE;
      len_q               <= '0;
      cyc_q               <= '0;
      err_q               <= 1'b0;
      nul_q               <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      bus.bus_req         <= 1'b0;
      bus.zxuno_addr      <= 8'h00;
      bus.regaddr_changed <= 1'b0;
      bus.zxuno_regrd     <= 1'b0;
    end else begin
      state_q             <= state_d;
      len_q               <= len_d;
      cyc_q               <= cyc_d;
      err_q               <= err_d;
      nul_q               <= nul_d;
      busy                <= (state_d != ST_IDLE);
      done                <= (state_d == ST_FIN);
      bus.bus_req         <= (state_d != ST_IDLE);
      bus.zxuno_addr      <= addr_driven(state_d) ? REG_ADDR : 8'h00;
      bus.regaddr_changed <= (state_d == ST_SELECT);
      bus.zxuno_regrd     <= (state_d == ST_RDON);
    end
  end

  assign len = len_q;
  assign err = err_q;

  coreid_buf #(.DEPTH(MAX_LEN)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (len_q[AW-1:0]),
    .wdata (bus.din),
    .raddr (rd_idx[AW-1:0]),
    .rdata (rd_data)
  );

`ifdef COREID_READER_CSUM_EN
  logic [7:0] csum_q;

  // Running mod-256 sum of captured bytes, cleared when a fetch starts.
  always_ff @(posedge clk) begin
    if (rst)                                 csum_q <= 8'h00;
    else if ((state_q == ST_IDLE) && start)  csum_q <= 8'h00;
    else if (buf_we)                         csum_q <= csum_q + bus.din;
  end

  assign csum = csum_q;
`else
  assign csum = 8'h00;
`endif

endmodule

// File: tb/tb_coreid_reader.sv
// Self-checking bench for coreid_reader with a behavioural ID-register responder.
module tb_coreid_reader;
  import zxuno_regs_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] rd_idx;
  logic       busy, done, err;
  logic [4:0] len;
  logic [7:0] rd_data, csum;

  coreid_reader_if bus();

  coreid_reader dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .len     (len),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .csum    (csum)
  );

  always #5 clk = ~clk;

  // Responder: index reset on address load, advanced on falling read strobe.
  logic [7:0] resp_mem [32];
  logic [4:0] resp_idx   = 5'd0;
  logic       prev_rd    = 1'b0;
  int         rd_pulses  = 0;
  int         rac_cycles = 0;
  int         rac_bad    = 0;
  int         done_cyc   = 0;

  assign bus.din = resp_mem[resp_idx];

  always @(negedge clk) begin
    prev_rd <= bus.zxuno_regrd;
    if (bus.zxuno_regrd && !prev_rd) rd_pulses <= rd_pulses + 1;
    if (done) done_cyc <= done_cyc + 1;
    if (bus.regaddr_changed) begin
      resp_idx   <= 5'd0;
      rac_cycles <= rac_cycles + 1;
      if (bus.zxuno_addr != REG_COREID) rac_bad <= rac_bad + 1;
    end else if (prev_rd && !bus.zxuno_regrd) begin
      resp_idx <= resp_idx + 5'd1;
    end
  end

  typedef struct {
    string s;
    int    exp_len;
    int    exp_reads;
    int    exp_csum;
  } vec_t;

  vec_t vecs[5];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_resp(input string s);
    for (int i = 0; i < 32; i++) resp_mem[i] = (i < s.len()) ? 8'(s[i]) : 8'h00;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 400 && !done; i++) tick();
    chk(name, int'(done), 1);
  endtask

  // Full fetch with grant held high; expectations go through the scoreboard queue.
  task automatic run_vec(input vec_t v);
    vec_t e;
    int   base_rd, base_done;
    load_resp(v.s);
    base_rd   = rd_pulses;
    base_done = done_cyc;
    exp_q.push_back(v);
    pulse_start();
    tick();
    chk("select_pulse", int'(bus.regaddr_changed), 1);
    chk("select_addr", int'(bus.zxuno_addr), 8'hFF);
    tick();
    chk("first_regrd_latency", int'(bus.zxuno_regrd), 1);
    wait_done("done_seen");
    e = exp_q.pop_front();
    chk("len", int'(len), e.exp_len);
    chk("err", int'(err), 0);
    chk("reads", rd_pulses - base_rd, e.exp_reads);
`ifdef COREID_READER_CSUM_EN
    chk("csum", int'(csum), e.exp_csum);
`else
    chk("csum", int'(csum), 0);
`endif
    for (int i = 0; i < e.exp_len; i++) begin
      rd_idx = 4'(i);
      #1;
      chk("rd_data", int'(rd_data), int'(8'(e.s[i])));
    end
    tick();
    chk("done_cleared", int'(done), 0);
    chk("busy_cleared", int'(busy), 0);
    chk("bus_req_cleared", int'(bus.bus_req), 0);
    chk("addr_cleared", int'(bus.zxuno_addr), 0);
    for (int i = 0; i < 10; i++) tick();
    chk("no_extra_read", rd_pulses - base_rd, e.exp_reads);
    chk("done_single_pulse", done_cyc - base_done, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_rd, base_rac, base_bad;

    vecs[0].s = "T19-25092015";       vecs[0].exp_len = 12; vecs[0].exp_reads = 13; vecs[0].exp_csum = 8'h83;
    vecs[1].s = "ABCDEFGHIJKLMNOPQR"; vecs[1].exp_len = 16; vecs[1].exp_reads = 16; vecs[1].exp_csum = 8'h88;
    vecs[2].s = "T19";                vecs[2].exp_len = 3;  vecs[2].exp_reads = 4;  vecs[2].exp_csum = 8'hBE;
    vecs[3].s = "";                   vecs[3].exp_len = 0;  vecs[3].exp_reads = 1;  vecs[3].exp_csum = 8'h00;
    vecs[4].s = "Z";                  vecs[4].exp_len = 1;  vecs[4].exp_reads = 2;  vecs[4].exp_csum = 8'h5A;

    rst = 1'b1; start = 1'b0; rd_idx = 4'd0; bus.bus_gnt = 1'b1;
    load_resp("");
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_len", int'(len), 0);
    chk("rst_csum", int'(csum), 0);
    chk("rst_bus_req", int'(bus.bus_req), 0);
    chk("rst_addr", int'(bus.zxuno_addr), 0);
    chk("rst_rac", int'(bus.regaddr_changed), 0);
    chk("rst_regrd", int'(bus.zxuno_regrd), 0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 5; k++) run_vec(vecs[k]);

    // Grant withheld for 5 cycles: nothing may happen on the bus before it arrives.
    bus.bus_gnt = 1'b0;
    load_resp("T19");
    base_rd = rd_pulses; base_rac = rac_cycles; base_bad = rac_bad;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      chk("pregnt_bus_req", int'(bus.bus_req), 1);
      chk("pregnt_rac", int'(bus.regaddr_changed), 0);
      chk("pregnt_regrd", int'(bus.zxuno_regrd), 0);
      tick();
    end
    bus.bus_gnt = 1'b1;
    tick();
    chk("gnt_select_pulse", int'(bus.regaddr_changed), 1);
    chk("gnt_select_addr", int'(bus.zxuno_addr), 8'hFF);
    tick();
    chk("gnt_rac_one_cycle", int'(bus.regaddr_changed), 0);
    chk("gnt_regrd", int'(bus.zxuno_regrd), 1);
    wait_done("gnt_done_seen");
    chk("gnt_len", int'(len), 3);
    chk("gnt_reads", rd_pulses - base_rd, 4);
    chk("gnt_rac_cycles", rac_cycles - base_rac, 1);
    chk("gnt_rac_addr_bad", rac_bad - base_bad, 0);
    repeat (3) tick();

    // Grant dropped during the 3rd read strobe: abort with two bytes kept.
    load_resp("T19-25092015");
    base_rd = rd_pulses;
    pulse_start();
    for (int i = 0; i < 200 && (rd_pulses - base_rd) < 3; i++) tick();
    chk("abort_third_read_seen", rd_pulses - base_rd, 3);
    bus.bus_gnt = 1'b0;
    tick();
    chk("abort_regrd_low", int'(bus.zxuno_regrd), 0);
    chk("abort_done", int'(done), 1);
    chk("abort_err", int'(err), 1);
    chk("abort_len", int'(len), 2);
    tick();
    chk("abort_busy_low", int'(busy), 0);
    chk("abort_err_held", int'(err), 1);
    bus.bus_gnt = 1'b1;
    repeat (2) tick();
    run_vec(vecs[0]);

    // Synchronous reset in the middle of a read strobe; start while busy is ignored.
    load_resp("T19-25092015");
    base_rd = rd_pulses;
    pulse_start();
    for (int i = 0; i < 200 && (rd_pulses - base_rd) < 2; i++) tick();
    chk("rst_mid_second_read_seen", rd_pulses - base_rd, 2);
    pulse_start();
    chk("busy_start_ignored_busy", int'(busy), 1);
    chk("busy_start_ignored_len", int'(len), 1);
    chk("busy_start_regrd", int'(bus.zxuno_regrd), 1);
    rst = 1'b1;
    tick();
    chk("midrst_regrd", int'(bus.zxuno_regrd), 0);
    chk("midrst_bus_req", int'(bus.bus_req), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_len", int'(len), 0);
    chk("midrst_addr", int'(bus.zxuno_addr), 0);
    chk("midrst_done", int'(done), 0);
    rst = 1'b0;
    repeat (4) tick();
    chk("postrst_idle_busy", int'(busy), 0);
    chk("postrst_idle_req", int'(bus.bus_req), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
